// File: rtl/instr_define.sv
// Shared MIPS encodings for the M-stage: memory opcodes, HI/LO functs,
// load_type codes, FSM state and access-size types.
package instr_define;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_LH      = 6'b100001;
  localparam logic [5:0] OP_LHU     = 6'b100101;
  localparam logic [5:0] OP_LB      = 6'b100000;
  localparam logic [5:0] OP_LBU     = 6'b100100;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_SH      = 6'b101001;
  localparam logic [5:0] OP_SB      = 6'b101000;

  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010;

  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LH  = 3'd1;
  localparam logic [2:0] LT_LHU = 3'd2;
  localparam logic [2:0] LT_LB  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } acc_size_e;

  function automatic acc_size_e op_size(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:         return SZ_WORD;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      default:              return SZ_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_be_gen.sv
// Byte-enable generation, store-lane replication and alignment check
// for the instruction held in the M stage.
module mem_be_gen
  import instr_define::*;
(
  input  logic [5:0]  op_i,
  input  logic        valid_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic        is_load_o,
  output logic        is_store_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        align_err_o
);

  acc_size_e size;

  always_comb begin
    size        = valid_i ? op_size(op_i) : SZ_NONE;
    is_store_o  = valid_i & ((op_i == OP_SW) | (op_i == OP_SH) | (op_i == OP_SB));
    is_load_o   = (size != SZ_NONE) & ~is_store_o;
    be_o        = 4'b0000;
    wdata_o     = wdata_i;
    align_err_o = 1'b0;

    // Loads always fetch the full word; the writeback stage extracts the lane.
    if (is_load_o) begin
      be_o = 4'b1111;
    end else if (is_store_o) begin
      case (size)
        SZ_WORD: be_o = 4'b1111;
        SZ_HALF: be_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        SZ_BYTE: be_o = 4'b0001 << addr_lo_i;
        default: be_o = 4'b0000;
      endcase
      if (size == SZ_BYTE) wdata_o = {4{wdata_i[7:0]}};
      else if (size == SZ_HALF) wdata_o = {2{wdata_i[15:0]}};
    end

    case (size)
      SZ_WORD: align_err_o = (addr_lo_i != 2'b00);
      SZ_HALF: align_err_o = addr_lo_i[0];
      default: align_err_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// E->M pipeline latch with stall/flush plus the MEM-stage data-memory
// request FSM (wait states, timeout, misalignment suppression).
module mem_stage_ctrl
  import instr_define::*;
#(
  parameter int ADDR_W   = 32,
  parameter int SIDE_W   = 1,
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_e,
  input  logic              valid_e,
  input  logic [ADDR_W-1:0] addr_e,
  input  logic [31:0]       wdata_e,
  input  logic [SIDE_W-1:0] side_e,
  input  logic              stall_in,
  input  logic              flush_m,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       instr_m,
  output logic              valid_m,
  output logic [SIDE_W-1:0] side_m,
  output logic [2:0]        load_type,
  output logic              ao_hl_sel,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [31:0]       rdata_q,
  output logic              mem_busy,
  output logic              align_err,
  output logic              bus_err
);

  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [SIDE_W-1:0] side_q, side_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_d;
  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;

  logic is_load, is_store, hold;

  mem_be_gen u_be_gen (
    .op_i        (instr_q[31:26]),
    .valid_i     (valid_q),
    .addr_lo_i   (addr_q[1:0]),
    .wdata_i     (wdata_q),
    .is_load_o   (is_load),
    .is_store_o  (is_store),
    .be_o        (mem_be),
    .wdata_o     (mem_wdata),
    .align_err_o (align_err)
  );

  assign instr_m   = instr_q;
  assign valid_m   = valid_q;
  assign side_m    = side_q;
  assign mem_addr  = addr_q;
  assign mem_we    = mem_req & is_store;
  assign mem_busy  = mem_req & ~mem_ready;
  assign ao_hl_sel = valid_q & (instr_q[31:26] == OP_SPECIAL) &
                     ((instr_q[5:0] == FN_MFHI) | (instr_q[5:0] == FN_MFLO));
  // A timeout ends the access like a completion, so it must not hold the latch.
  assign hold      = stall_in | (mem_busy & ~bus_err);

  always_comb begin
    load_type = LT_LW;
    if (is_load) begin
      case (instr_q[31:26])
        OP_LH:   load_type = LT_LH;
        OP_LHU:  load_type = LT_LHU;
        OP_LB:   load_type = LT_LB;
        OP_LBU:  load_type = LT_LBU;
        default: load_type = LT_LW;
      endcase
    end
  end

  always_comb begin
    instr_d = instr_q;
    valid_d = valid_q;
    side_d  = side_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (!hold) begin
      if (flush_m) begin
        instr_d = '0;
        valid_d = 1'b0;
        side_d  = '0;
        addr_d  = '0;
        wdata_d = '0;
      end else begin
        instr_d = instr_e;
        valid_d = valid_e;
        side_d  = side_e;
        addr_d  = addr_e;
        wdata_d = wdata_e;
      end
    end
  end

  assign rdata_d = (mem_req & mem_ready) ? mem_rdata : rdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_req = 1'b0;
    bus_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mem_req = (is_load | is_store) & ~align_err;
        if (mem_req) begin
          if (mem_ready) begin
            state_d = stall_in ? ST_DONE : ST_IDLE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_W'(1);
          end
        end
      end
      ST_WAIT: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          state_d = stall_in ? ST_DONE : ST_IDLE;
        end else if (cnt_q == WAIT_W'(MAX_WAIT)) begin
          bus_err = 1'b1;
          state_d = stall_in ? ST_DONE : ST_IDLE;
        end else begin
          cnt_d = cnt_q + WAIT_W'(1);
        end
      end
      // Access finished but the stage is stalled: keep quiet until it advances.
      ST_DONE: begin
        if (!stall_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= '0;
      valid_q <= 1'b0;
      side_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      instr_q <= instr_d;
      valid_q <= valid_d;
      side_q  <= side_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scenario bench for mem_stage_ctrl: expected bus transactions are queued
// when an instruction enters E and compared when the memory completes it.
module tb_mem_stage_ctrl;
  import instr_define::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_e;
  logic        valid_e;
  logic [31:0] addr_e;
  logic [31:0] wdata_e;
  logic [0:0]  side_e;
  logic        stall_in, flush_m, mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] instr_m;
  logic        valid_m;
  logic [0:0]  side_m;
  logic [2:0]  load_type;
  logic        ao_hl_sel, mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, rdata_q;
  logic        mem_busy, align_err, bus_err;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  typedef struct packed {
    bus_t        bus;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  bus_t obs;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl dut (
    .clk(clk), .reset(reset), .instr_e(instr_e), .valid_e(valid_e), .addr_e(addr_e),
    .wdata_e(wdata_e), .side_e(side_e), .stall_in(stall_in), .flush_m(flush_m),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .instr_m(instr_m), .valid_m(valid_m),
    .side_m(side_m), .load_type(load_type), .ao_hl_sel(ao_hl_sel), .mem_req(mem_req),
    .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .rdata_q(rdata_q), .mem_busy(mem_busy), .align_err(align_err), .bus_err(bus_err)
  );

  function automatic logic [31:0] ins(input logic [5:0] op, input logic [5:0] fn);
    return {op, 5'd3, 5'd4, 10'd0, fn};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_e(input logic [31:0] i, input logic [31:0] a,
                         input logic [31:0] w, input logic s);
    instr_e = i; valid_e = 1'b1; addr_e = a; wdata_e = w; side_e = s;
  endtask

  task automatic bubble();
    instr_e = '0; valid_e = 1'b0; addr_e = '0; wdata_e = '0; side_e = '0;
  endtask

  task automatic settle();
    bubble();
    stall_in = 1'b0; flush_m = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    step();
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_e(ins(OP_SW, 6'd0), 32'h0000_0104, 32'hFFFF_FFFF, 1'b1);
    stall_in = 1'b0; flush_m = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    step(); step(); step();
    checks++;
    if ({instr_m, valid_m, side_m, load_type, ao_hl_sel, mem_req, mem_we, mem_be, mem_addr,
         mem_wdata, rdata_q, mem_busy, align_err, bus_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs instr_m=%h mem_req=%b mem_be=%b mem_addr=%h rdata_q=%h required all zero",
               instr_m, mem_req, mem_be, mem_addr, rdata_q);
    end
    checks++;
    if (dut.state_q !== ST_IDLE) begin
      errors++; $display("FAIL reset_state got %0d required %0d", dut.state_q, ST_IDLE);
    end
    reset = 1'b1;
    settle();
  endtask

  task automatic test_sb_zero_wait();
    drive_e(ins(OP_SB, 6'd0), 32'h0000_1003, 32'h1234_56AB, 1'b0);
    sb_q.push_back('{bus: '{we: 1'b1, be: 4'b1000, addr: 32'h0000_1003, wdata: 32'hABAB_ABAB},
                     rdata: 32'h0000_0077});
    step();
    drive_e(ins(OP_SPECIAL, 6'b100000), 32'h0, 32'h0, 1'b0);
    mem_ready = 1'b1;
    if (sb_q.size() != 0) mem_rdata = sb_q[0].rdata;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_busy !== 1'b0) begin
      errors++; $display("FAIL sb_req_busy req=%b busy=%b required 1 0", mem_req, mem_busy);
    end
    checks++;
    if (sb_q.size() == 0) begin
      errors++; $display("FAIL sb_scoreboard empty queue at completion");
    end else begin
      e = sb_q.pop_front();
      obs = {mem_we, mem_be, mem_addr, mem_wdata};
      if (obs !== e.bus) begin
        errors++; $display("FAIL sb_bus got %h required %h", obs, e.bus);
      end
    end
    step();
    checks++;
    if (instr_m !== ins(OP_SPECIAL, 6'b100000) || mem_req !== 1'b0) begin
      errors++; $display("FAIL sb_advance instr_m=%h req=%b required %h 0",
                         instr_m, mem_req, ins(OP_SPECIAL, 6'b100000));
    end
    settle();
  endtask

  task automatic test_lw_wait();
    int  busy_n;
    bit  done;
    busy_n = 0; done = 0;
    drive_e(ins(OP_LW, 6'd0), 32'h0000_0010, 32'h0, 1'b0);
    sb_q.push_back('{bus: '{we: 1'b0, be: 4'b1111, addr: 32'h0000_0010, wdata: 32'h0},
                     rdata: 32'h89AB_CDEF});
    step();
    bubble();
    for (int i = 0; i < 20 && !done; i++) begin
      if (i == 3) begin
        mem_ready = 1'b1;
        if (sb_q.size() != 0) mem_rdata = sb_q[0].rdata;
      end
      #1;
      if (mem_busy) busy_n++;
      if (i == 1) begin
        checks++;
        if (load_type !== LT_LW || instr_m !== ins(OP_LW, 6'd0) || mem_req !== 1'b1) begin
          errors++; $display("FAIL lw_wait_hold load_type=%0d instr_m=%h req=%b", load_type, instr_m, mem_req);
        end
      end
      if (mem_req && mem_ready) begin
        done = 1;
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL lw_scoreboard empty queue at completion");
        end else begin
          e = sb_q.pop_front();
          obs = {mem_we, mem_be, mem_addr, mem_wdata};
          if (obs !== e.bus) begin
            errors++; $display("FAIL lw_bus got %h required %h", obs, e.bus);
          end
        end
      end
      step();
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL lw_complete no completion within 20 cycles");
    end
    checks++;
    if (busy_n != 3) begin
      errors++; $display("FAIL lw_busy_cycles got %0d required 3", busy_n);
    end
    checks++;
    if (rdata_q !== 32'h89AB_CDEF || instr_m !== 32'h0) begin
      errors++; $display("FAIL lw_rdata rdata_q=%h instr_m=%h required 89abcdef 0", rdata_q, instr_m);
    end
    settle();
  endtask

  task automatic test_timeout();
    bit found;
    found = 0;
    drive_e(ins(OP_LW, 6'd0), 32'h0000_0020, 32'h0, 1'b0);
    step();
    bubble();
    for (int i = 0; i < 40 && !found; i++) begin
      #1;
      if (bus_err) begin
        found = 1;
        checks++;
        if (i != 15 || mem_req !== 1'b1) begin
          errors++; $display("FAIL timeout_cycle bus_err at cycle %0d req=%b required cycle 15 req 1", i, mem_req);
        end
      end
      step();
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL timeout_seen bus_err never asserted within 40 cycles");
    end
    #1;
    checks++;
    if (mem_req !== 1'b0 || bus_err !== 1'b0 || instr_m !== 32'h0 || dut.state_q !== ST_IDLE) begin
      errors++; $display("FAIL timeout_after req=%b bus_err=%b instr_m=%h state=%0d required 0 0 0 0",
                         mem_req, bus_err, instr_m, dut.state_q);
    end
    settle();
  endtask

  task automatic test_misalign();
    drive_e(ins(OP_LH, 6'd0), 32'h0000_0021, 32'h0, 1'b0);
    step();
    drive_e(ins(OP_SW, 6'd0), 32'h0000_0022, 32'h5555_AAAA, 1'b0);
    #1;
    checks++;
    if (align_err !== 1'b1 || mem_req !== 1'b0 || mem_busy !== 1'b0 || load_type !== LT_LH) begin
      errors++; $display("FAIL lh_misalign align=%b req=%b busy=%b lt=%0d required 1 0 0 1",
                         align_err, mem_req, mem_busy, load_type);
    end
    step();
    drive_e(ins(OP_SPECIAL, 6'b100001), 32'h0, 32'h0, 1'b0);
    #1;
    checks++;
    if (instr_m !== ins(OP_SW, 6'd0) || align_err !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL sw_misalign instr_m=%h align=%b req=%b we=%b", instr_m, align_err, mem_req, mem_we);
    end
    step();
    checks++;
    if (instr_m !== ins(OP_SPECIAL, 6'b100001) || align_err !== 1'b0) begin
      errors++; $display("FAIL misalign_advance instr_m=%h align=%b", instr_m, align_err);
    end
    settle();
  endtask

  task automatic test_flush_stall();
    instr_e = ins(OP_SPECIAL, FN_MFHI); valid_e = 1'b0;
    step();
    checks++;
    if (ao_hl_sel !== 1'b0) begin
      errors++; $display("FAIL hl_sel_invalid got %b required 0", ao_hl_sel);
    end
    drive_e(ins(OP_SPECIAL, FN_MFHI), 32'h0, 32'h0, 1'b0);
    step();
    checks++;
    if (ao_hl_sel !== 1'b1 || load_type !== LT_LW) begin
      errors++; $display("FAIL hl_sel_mfhi got %b lt=%0d required 1 0", ao_hl_sel, load_type);
    end
    stall_in = 1'b1; flush_m = 1'b1;
    drive_e(ins(OP_SPECIAL, FN_MFLO), 32'h0, 32'h0, 1'b1);
    step();
    checks++;
    if (instr_m !== ins(OP_SPECIAL, FN_MFHI) || valid_m !== 1'b1) begin
      errors++; $display("FAIL flush_in_stall instr_m=%h valid=%b required %h 1",
                         instr_m, valid_m, ins(OP_SPECIAL, FN_MFHI));
    end
    stall_in = 1'b0; flush_m = 1'b0;
    step();
    checks++;
    if (instr_m !== ins(OP_SPECIAL, FN_MFLO) || ao_hl_sel !== 1'b1 || side_m !== 1'b1) begin
      errors++; $display("FAIL mflo_latch instr_m=%h hl=%b side=%b", instr_m, ao_hl_sel, side_m);
    end
    flush_m = 1'b1;
    step();
    checks++;
    if (instr_m !== 32'h0 || valid_m !== 1'b0 || side_m !== 1'b0) begin
      errors++; $display("FAIL flush_bubble instr_m=%h valid=%b side=%b required 0 0 0", instr_m, valid_m, side_m);
    end
    settle();
  endtask

  task automatic test_done_stall();
    drive_e(ins(OP_LW, 6'd0), 32'h0000_0040, 32'h0, 1'b1);
    sb_q.push_back('{bus: '{we: 1'b0, be: 4'b1111, addr: 32'h0000_0040, wdata: 32'h0},
                     rdata: 32'hCAFE_F00D});
    step();
    drive_e(ins(OP_SPECIAL, 6'b100011), 32'h0, 32'h0, 1'b0);
    stall_in = 1'b1; mem_ready = 1'b1;
    if (sb_q.size() != 0) mem_rdata = sb_q[0].rdata;
    #1;
    checks++;
    if (sb_q.size() == 0 || mem_req !== 1'b1 || side_m !== 1'b1) begin
      errors++; $display("FAIL done_first_req req=%b side=%b queue=%0d", mem_req, side_m, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      obs = {mem_we, mem_be, mem_addr, mem_wdata};
      if (obs !== e.bus) begin
        errors++; $display("FAIL done_bus got %h required %h", obs, e.bus);
      end
    end
    step();
    mem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (mem_req !== 1'b0 || instr_m !== ins(OP_LW, 6'd0) || dut.state_q !== ST_DONE) begin
        errors++; $display("FAIL done_hold cycle %0d req=%b instr_m=%h state=%0d required 0 lw DONE",
                           i, mem_req, instr_m, dut.state_q);
      end
      step();
    end
    checks++;
    if (rdata_q !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL done_rdata got %h required cafef00d", rdata_q);
    end
    stall_in = 1'b0; mem_ready = 1'b0;
    step();
    checks++;
    if (instr_m !== ins(OP_SPECIAL, 6'b100011) || dut.state_q !== ST_IDLE || mem_req !== 1'b0) begin
      errors++; $display("FAIL done_release instr_m=%h state=%0d req=%b", instr_m, dut.state_q, mem_req);
    end
    settle();
  endtask

  task automatic test_reset_mid_wait();
    drive_e(ins(OP_LW, 6'd0), 32'h0000_0050, 32'h0, 1'b0);
    step();
    bubble();
    step();
    #1;
    checks++;
    if (dut.state_q !== ST_WAIT || mem_busy !== 1'b1) begin
      errors++; $display("FAIL rst_pre_wait state=%0d busy=%b required WAIT 1", dut.state_q, mem_busy);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL rst_async_req got %b required 0", mem_req);
    end
    step();
    checks++;
    if (mem_req !== 1'b0 || instr_m !== 32'h0 || bus_err !== 1'b0 || dut.state_q !== ST_IDLE) begin
      errors++; $display("FAIL rst_mid_wait req=%b instr_m=%h bus_err=%b state=%0d required 0 0 0 IDLE",
                         mem_req, instr_m, bus_err, dut.state_q);
    end
    reset = 1'b1;
    settle();
  endtask

  logic [5:0]  bb_op [5] = '{OP_SW, OP_SH, OP_LB, OP_LBU, OP_LH};
  logic [31:0] bb_ad [5] = '{32'h104, 32'h106, 32'h10B, 32'h10C, 32'h10E};
  logic [31:0] bb_wd [5] = '{32'h1122_3344, 32'hAAAA_5566, 32'h0, 32'h0, 32'h0};
  logic [31:0] bb_xw [5] = '{32'h1122_3344, 32'h5566_5566, 32'h0, 32'h0, 32'h0};
  logic [3:0]  bb_be [5] = '{4'b1111, 4'b1100, 4'b1111, 4'b1111, 4'b1111};
  logic        bb_we [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [2:0]  bb_lt [5] = '{LT_LW, LT_LW, LT_LB, LT_LBU, LT_LH};
  logic [31:0] bb_rd [5] = '{32'h101, 32'h202, 32'hF1, 32'hF2, 32'h8003};

  task automatic test_back_to_back();
    mem_ready = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      if (k < 5) begin
        drive_e(ins(bb_op[k], 6'd0), bb_ad[k], bb_wd[k], 1'b0);
        sb_q.push_back('{bus: '{we: bb_we[k], be: bb_be[k], addr: bb_ad[k], wdata: bb_xw[k]},
                         rdata: bb_rd[k]});
      end else begin
        bubble();
      end
      if (k > 0) begin
        mem_rdata = sb_q[0].rdata;
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_busy !== 1'b0 || load_type !== bb_lt[k-1]) begin
          errors++; $display("FAIL b2b_ctrl item %0d req=%b busy=%b lt=%0d required 1 0 %0d",
                             k - 1, mem_req, mem_busy, load_type, bb_lt[k-1]);
        end
        checks++;
        e = sb_q.pop_front();
        obs = {mem_we, mem_be, mem_addr, mem_wdata};
        if (obs !== e.bus) begin
          errors++; $display("FAIL b2b_bus item %0d got %h required %h", k - 1, obs, e.bus);
        end
      end
      step();
      if (k > 0) begin
        checks++;
        if (rdata_q !== bb_rd[k-1]) begin
          errors++; $display("FAIL b2b_rdata item %0d got %h required %h", k - 1, rdata_q, bb_rd[k-1]);
        end
      end
    end
    settle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bubble();
    stall_in = 1'b0; flush_m = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    test_reset();
    test_sb_zero_wait();
    test_lw_wait();
    test_timeout();
    test_misalign();
    test_flush_stall();
    test_done_stall();
    test_reset_mid_wait();
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover %0d entries required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
